// File: rtl/reset_release_sequencer.sv
// Reset generator: asserts all outputs asynchronously on rst, synchronises the release into clk,
// then releases rst_out[0..N-1] in index order after HOLD_CYCLES, spaced by STEP_CYCLES.
module reset_release_sequencer #(
    parameter int SYNC_STAGES = 2,
    parameter int NUM_OUTPUTS = 4,
    parameter int HOLD_CYCLES = 8,
    parameter int STEP_CYCLES = 4,
    parameter logic [NUM_OUTPUTS-1:0] ASSERT_VAL = {NUM_OUTPUTS{1'b1}}
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   sw_req,
    output logic [NUM_OUTPUTS-1:0] rst_out,
    output logic                   done
);

    localparam int MAX_CYC = (HOLD_CYCLES > STEP_CYCLES) ? HOLD_CYCLES : STEP_CYCLES;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam int IDX_W   = (NUM_OUTPUTS > 1) ? $clog2(NUM_OUTPUTS) : 1;

    typedef enum logic [1:0] {
        S_SYNC = 2'd0,
        S_HOLD = 2'd1,
        S_STEP = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [NUM_OUTPUTS-1:0] rst_out_q, rst_out_d;
    logic                   done_q, done_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rel_ok;

    // Chain is cleared by any rst pulse, however short, so release always re-synchronises.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign rel_ok = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_SYNC;
            cnt_q     <= '0;
            idx_q     <= '0;
            rst_out_q <= ASSERT_VAL;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            rst_out_q <= rst_out_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        rst_out_d = rst_out_q;
        done_d    = done_q;
        case (state_q)
            S_SYNC: begin
                if (rel_ok) begin
                    state_d = S_HOLD;
                    cnt_d   = '0;
                end
            end
            S_HOLD: begin
                if (int'(cnt_q) >= HOLD_CYCLES - 1) begin
                    rst_out_d[0] = ~ASSERT_VAL[0];
                    idx_d        = '0;
                    cnt_d        = '0;
                    if (NUM_OUTPUTS == 1) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_STEP;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_STEP: begin
                if (int'(cnt_q) >= STEP_CYCLES - 1) begin
                    for (int i = 0; i < NUM_OUTPUTS; i++) begin
                        if (i == int'(idx_q) + 1) begin
                            rst_out_d[i] = ~ASSERT_VAL[i];
                        end
                    end
                    idx_d = idx_q + IDX_W'(1);
                    cnt_d = '0;
                    if (int'(idx_q) + 1 >= NUM_OUTPUTS - 1) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                // sw_req is only honoured here; a held request restarts once per completed sequence.
                if (sw_req) begin
                    state_d   = S_HOLD;
                    cnt_d     = '0;
                    idx_d     = '0;
                    rst_out_d = ASSERT_VAL;
                    done_d    = 1'b0;
                end
            end
            default: begin
                state_d = S_SYNC;
            end
        endcase
    end

    assign rst_out = rst_out_q;
    assign done    = done_q;

endmodule

// File: tb/tb_reset_release_sequencer.sv
// Scoreboard bench: stimulus pushes hand-computed {rst_out, done} per edge, a monitor pops and compares.
module tb_reset_release_sequencer;

    typedef struct packed {
        logic       sel;
        logic [2:0] ro;
        logic       d;
        logic [7:0] ph;
        logic [7:0] n;
    } exp_t;

    logic       clk     = 1'b0;
    logic       clk_en  = 1'b0;
    logic       rst     = 1'b0;
    logic       rst2    = 1'b0;
    logic       sw_req  = 1'b0;
    logic       sw_req2 = 1'b0;
    logic [2:0] ro;
    logic       dn;
    logic [0:0] ro2;
    logic       dn2;

    exp_t q[$];
    event chk_ev;
    int   total  = 0;
    int   passed = 0;

    reset_release_sequencer #(
        .SYNC_STAGES(2), .NUM_OUTPUTS(3), .HOLD_CYCLES(4), .STEP_CYCLES(2), .ASSERT_VAL(3'b011)
    ) dut (
        .clk(clk), .rst(rst), .sw_req(sw_req), .rst_out(ro), .done(dn)
    );

    reset_release_sequencer #(
        .NUM_OUTPUTS(1), .HOLD_CYCLES(1)
    ) dut1 (
        .clk(clk), .rst(rst2), .sw_req(sw_req2), .rst_out(ro2), .done(dn2)
    );

    initial forever begin
        #5;
        if (clk_en) clk = ~clk;
    end

    // Expected {rst_out, done} for the 3-output config, p edges after HOLD entry (p<0: not yet).
    function automatic logic [3:0] exp3(input int p);
        if (p < 4)      return 4'b0110;
        else if (p < 6) return 4'b0100;
        else if (p < 8) return 4'b0000;
        else            return 4'b1001;
    endfunction

    task automatic push(input logic sel, input logic [3:0] rd, input int ph, input int n);
        exp_t e;
        e.sel = sel;
        e.ro  = rd[3:1];
        e.d   = rd[0];
        e.ph  = 8'(ph);
        e.n   = 8'(n);
        q.push_back(e);
    endtask

    task automatic at_edge(input logic sel, input logic [3:0] rd, input int ph, input int n);
        @(posedge clk);
        push(sel, rd, ph, n);
        #2;
    endtask

    initial begin
        exp_t       e;
        logic [2:0] a_ro;
        logic       a_d;
        forever begin
            @(negedge clk or chk_ev);
            while (q.size() > 0) begin
                e = q.pop_front();
                if (e.sel) begin
                    a_ro = {2'b00, ro2};
                    a_d  = dn2;
                end else begin
                    a_ro = ro;
                    a_d  = dn;
                end
                total++;
                if (a_ro === e.ro && a_d === e.d) passed++;
                else $display("FAIL phase%0d edge%0d: rst_out=%b done=%b, required rst_out=%b done=%b",
                              e.ph, e.n, a_ro, a_d, e.ro, e.d);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset asserted with the clock stopped: outputs must take reset values with no edge.
        #1 rst = 1'b1; rst2 = 1'b1;
        #1 push(1'b0, 4'b0110, 0, 0); push(1'b1, 4'b0010, 0, 0); -> chk_ev;
        #1 rst = 1'b0; clk_en = 1'b1;

        for (int n = 1; n <= 8; n++) at_edge(1'b0, exp3(n - 3), 1, n);

        // Sub-period rst pulse between edges 8 and 9.
        @(negedge clk);
        #1 rst = 1'b1;
        #1 push(1'b0, 4'b0110, 2, 0); -> chk_ev;
        #1 rst = 1'b0;
        for (int n = 1; n <= 12; n++) at_edge(1'b0, exp3(n - 3), 2, n);

        // One-cycle sw_req from DONE.
        sw_req = 1'b1;
        at_edge(1'b0, exp3(0), 3, 0);
        sw_req = 1'b0;
        for (int k = 1; k <= 9; k++) at_edge(1'b0, exp3(k), 3, k);

        // Held sw_req: restarts every 9 edges, done pulses for one cycle.
        sw_req = 1'b1;
        for (int k = 0; k < 27; k++) at_edge(1'b0, exp3(k % 9), 4, k);
        sw_req = 1'b0;
        at_edge(1'b0, 4'b1001, 4, 27);

        // Single output, HOLD_CYCLES=1: release and done at edge 4.
        rst2 = 1'b0;
        for (int n = 1; n <= 6; n++) at_edge(1'b1, (n < 4) ? 4'b0010 : 4'b0001, 5, n);

        @(negedge clk);
        #1;
        if (q.size() != 0) begin
            total++;
            $display("FAIL drain: %0d expectations unchecked, required 0", q.size());
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
